// File: rtl/stage_memory.sv
// stage_memory: pipeline MEM stage sitting directly upstream of writeback.
// Performs loads/stores over a req/ack data bus, aligns and extends load data,
// and owns the MEM/WB pipeline register. Upstream is stalled while an access
// is outstanding; EX/MEM inputs are held stable by upstream during a stall.
//
// WB_Control layout (3 bits): [2:1] WritebackSrc, [0] RegWrite.
module stage_memory #(
  parameter int ACK_TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_Valid,
  input  logic [2:0]  i_WB_Control,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_AluOutput,
  input  logic [31:0] i_StoreData,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_MemFunct3,
  output logic        o_Stall,
  output logic        o_DBus_Req,
  output logic        o_DBus_We,
  output logic [31:0] o_DBus_Addr,
  output logic [31:0] o_DBus_WData,
  output logic [3:0]  o_DBus_ByteEn,
  input  logic        i_DBus_Ack,
  input  logic [31:0] i_DBus_RData,
  output logic        o_Valid,
  output logic [2:0]  o_WB_Control,
  output logic [4:0]  o_rd,
  output logic [31:0] o_AluOutput,
  output logic [31:0] o_MemoryValue,
  output logic        o_Fault
);

  // Counter only needs to hold values up to ACK_TIMEOUT-1.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic TO_EN = (ACK_TIMEOUT > 0);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_DBus_Req;
  logic            r_DBus_We;
  logic [31:0]     r_DBus_Addr;
  logic [31:0]     r_DBus_WData;
  logic [3:0]      r_DBus_ByteEn;

  logic            r_Valid;
  logic [2:0]      r_WB_Control;
  logic [4:0]      r_rd;
  logic [31:0]     r_AluOutput;
  logic [31:0]     r_MemoryValue;
  logic            r_Fault;

  logic            w_memop;
  logic            w_bad_f3;
  logic            w_misalign;
  logic            w_bad;
  logic            w_good;
  logic            w_ack;
  logic            w_timeout;
  logic            w_stall;
  logic            w_fault_now;
  logic [3:0]      w_byteen;
  logic [31:0]     w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_value;

  assign w_memop    = i_Valid & (i_MemRead | i_MemWrite);
  assign w_bad_f3   = (i_MemFunct3 == 3'b011) | (i_MemFunct3 == 3'b110) |
                      (i_MemFunct3 == 3'b111);
  assign w_misalign = ((i_MemFunct3 == F3_H) | (i_MemFunct3 == F3_HU)) ? i_AluOutput[0]
                    : (i_MemFunct3 == F3_W) ? (i_AluOutput[1:0] != 2'b00)
                    : 1'b0;
  assign w_bad      = w_memop & ((i_MemRead & i_MemWrite) | w_bad_f3 | w_misalign);
  assign w_good     = w_memop & ~w_bad;

  // Ack only counts while a request is actually on the bus.
  assign w_ack      = (r_state == ST_ACCESS) & r_DBus_Req & i_DBus_Ack;
  // Ack in the last allowed cycle wins over the timeout.
  assign w_timeout  = TO_EN & (r_state == ST_ACCESS) & ~w_ack & (r_cnt == TO_LAST);
  assign w_stall    = (r_state == ST_IDLE) ? w_good : ~(w_ack | w_timeout);
  assign w_fault_now = ((r_state == ST_IDLE) & w_bad) | w_timeout;

  // Store lane steering: replicate data across lanes, enable the addressed bytes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_byteen = 4'b1111;
    w_wdata  = i_StoreData;
    case (i_MemFunct3[1:0])
      2'b00: begin
        w_byteen = 4'b0001 << i_AluOutput[1:0];
        w_wdata  = {4{i_StoreData[7:0]}};
      end
      2'b01: begin
        w_byteen = i_AluOutput[1] ? 4'b1100 : 4'b0011;
        w_wdata  = {2{i_StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and sign/zero extension of the returned word.
  always_comb begin
    case (i_AluOutput[1:0])
      2'b00:   w_byte = i_DBus_RData[7:0];
      2'b01:   w_byte = i_DBus_RData[15:8];
      2'b10:   w_byte = i_DBus_RData[23:16];
      default: w_byte = i_DBus_RData[31:24];
    endcase
    w_half = i_AluOutput[1] ? i_DBus_RData[31:16] : i_DBus_RData[15:0];
    case (i_MemFunct3)
      F3_B:    w_load_value = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load_value = {{16{w_half[15]}}, w_half};
      F3_BU:   w_load_value = {24'h0, w_byte};
      F3_HU:   w_load_value = {16'h0, w_half};
      default: w_load_value = i_DBus_RData;
    endcase
  end

  // Access FSM: owns the bus request, registered bus fields and timeout counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_DBus_Req    <= 1'b0;
      r_DBus_We     <= 1'b0;
      r_DBus_Addr   <= '0;
      r_DBus_WData  <= '0;
      r_DBus_ByteEn <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_good) begin
            r_state       <= ST_ACCESS;
            r_DBus_Req    <= 1'b1;
            r_DBus_We     <= i_MemWrite;
            r_DBus_Addr   <= {i_AluOutput[31:2], 2'b00};
            r_DBus_WData  <= w_wdata;
            r_DBus_ByteEn <= w_byteen;
          end
        end
        ST_ACCESS: begin
          if (w_ack || w_timeout) begin
            r_state    <= ST_IDLE;
            r_DBus_Req <= 1'b0;
            r_cnt      <= '0;
          end else if (TO_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the finishing instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_Valid       <= 1'b0;
      r_WB_Control  <= '0;
      r_rd          <= '0;
      r_AluOutput   <= '0;
      r_MemoryValue <= '0;
      r_Fault       <= 1'b0;
    end else if (w_stall) begin
      r_Valid       <= 1'b0;
      r_WB_Control  <= '0;
      r_rd          <= '0;
      r_AluOutput   <= '0;
      r_MemoryValue <= '0;
      r_Fault       <= 1'b0;
    end else begin
      r_Valid       <= i_Valid;
      r_WB_Control  <= {i_WB_Control[2:1], i_WB_Control[0] & ~w_fault_now};
      r_rd          <= i_rd;
      r_AluOutput   <= i_AluOutput;
      r_MemoryValue <= (w_ack && i_MemRead) ? w_load_value : 32'h0;
      r_Fault       <= w_fault_now;
    end
  end

  assign o_Stall       = w_stall;
  assign o_DBus_Req    = r_DBus_Req;
  assign o_DBus_We     = r_DBus_We;
  assign o_DBus_Addr   = r_DBus_Addr;
  assign o_DBus_WData  = r_DBus_WData;
  assign o_DBus_ByteEn = r_DBus_ByteEn;
  assign o_Valid       = r_Valid;
  assign o_WB_Control  = r_WB_Control;
  assign o_rd          = r_rd;
  assign o_AluOutput   = r_AluOutput;
  assign o_MemoryValue = r_MemoryValue;
  assign o_Fault       = r_Fault;

endmodule

// File: tb/tb_stage_memory.sv
// tb_stage_memory: drives instructions through the MEM stage and compares the
// MEM/WB result, stall/request timing and bus fields against a behavioural model.
module tb_stage_memory;
  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_Valid = 1'b0;
  logic [2:0]  i_WB_Control = '0;
  logic [4:0]  i_rd = '0;
  logic [31:0] i_AluOutput = '0;
  logic [31:0] i_StoreData = '0;
  logic        i_MemRead = 1'b0;
  logic        i_MemWrite = 1'b0;
  logic [2:0]  i_MemFunct3 = '0;
  logic        i_DBus_Ack = 1'b0;
  logic [31:0] i_DBus_RData = '0;
  logic        o_Stall, o_DBus_Req, o_DBus_We, o_Valid, o_Fault;
  logic [31:0] o_DBus_Addr, o_DBus_WData, o_AluOutput, o_MemoryValue;
  logic [3:0]  o_DBus_ByteEn;
  logic [2:0]  o_WB_Control;
  logic [4:0]  o_rd;

  int n_checks = 0;
  int n_errors = 0;

  stage_memory #(.ACK_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_Valid(i_Valid), .i_WB_Control(i_WB_Control),
    .i_rd(i_rd), .i_AluOutput(i_AluOutput), .i_StoreData(i_StoreData),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_MemFunct3(i_MemFunct3),
    .o_Stall(o_Stall), .o_DBus_Req(o_DBus_Req), .o_DBus_We(o_DBus_We),
    .o_DBus_Addr(o_DBus_Addr), .o_DBus_WData(o_DBus_WData), .o_DBus_ByteEn(o_DBus_ByteEn),
    .i_DBus_Ack(i_DBus_Ack), .i_DBus_RData(i_DBus_RData), .o_Valid(o_Valid),
    .o_WB_Control(o_WB_Control), .o_rd(o_rd), .o_AluOutput(o_AluOutput),
    .o_MemoryValue(o_MemoryValue), .o_Fault(o_Fault)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        fault;
    int          stall_cycles;
    int          req_cycles;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic        we;
  } res_t;

  // Behavioural model: what writeback and the bus should see for one instruction
  // whose ack arrives `delay` cycles after the first request cycle.
  function automatic res_t model(logic v, logic [2:0] ctl, logic [4:0] rd, logic [31:0] alu,
                                 logic [31:0] sd, logic mr, logic mw, logic [2:0] f3,
                                 logic [31:0] rdata, int delay);
    res_t e;
    int size, off;
    logic [31:0] mask, raw;
    bit memop, bad, tout;
    e = '{valid: v, ctl: ctl, rd: rd, alu: alu, mem: 32'h0, fault: 1'b0, stall_cycles: 0,
          req_cycles: 0, addr: 32'h0, wdata: 32'h0, byteen: 4'h0, we: 1'b0};
    memop = v && (mr || mw);
    size  = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    off   = int'(alu[1:0]);
    bad   = memop && ((mr && mw) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (off % size) != 0);
    if (!memop) return e;
    if (bad) begin
      e.ctl[0] = 1'b0;
      e.fault  = 1'b1;
      return e;
    end
    tout = (delay >= TO);
    e.req_cycles   = tout ? TO : delay + 1;
    e.stall_cycles = e.req_cycles;
    e.addr   = alu - 32'(off);
    e.byteen = 4'((32'h1 << size) - 32'h1) << off;
    mask     = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    e.wdata  = (size == 1) ? (sd & mask) * 32'h0101_0101 :
               (size == 2) ? (sd & mask) * 32'h0001_0001 : sd;
    e.we     = mw;
    if (tout) begin
      e.fault  = 1'b1;
      e.ctl[0] = 1'b0;
    end else if (mr) begin
      raw = (rdata >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
      e.mem = raw;
    end
    return e;
  endfunction

  // Presents one instruction, acks the bus after `delay` request cycles and
  // records what the DUT did until the instruction lands in MEM/WB.
  task automatic run_op(input logic v, input logic [2:0] ctl, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sd, input logic mr,
                        input logic mw, input logic [2:0] f3, input logic [31:0] rdata,
                        input int delay, output res_t o, output int bad_bubbles,
                        output int unstable, output bit hung);
    bit done, was_stall;
    int cyc;
    o = '{valid: 1'b0, ctl: 3'h0, rd: 5'h0, alu: 32'h0, mem: 32'h0, fault: 1'b0,
          stall_cycles: 0, req_cycles: 0, addr: 32'h0, wdata: 32'h0, byteen: 4'h0, we: 1'b0};
    i_Valid = v; i_WB_Control = ctl; i_rd = rd; i_AluOutput = alu; i_StoreData = sd;
    i_MemRead = mr; i_MemWrite = mw; i_MemFunct3 = f3; i_DBus_Ack = 1'b0;
    i_DBus_RData = $urandom;
    #1;
    done = 0; cyc = 0; bad_bubbles = 0; unstable = 0;
    while (!done && cyc < 64) begin
      if (o_DBus_Req === 1'b1) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.addr = o_DBus_Addr; o.wdata = o_DBus_WData; o.byteen = o_DBus_ByteEn; o.we = o_DBus_We;
        end else if ({o_DBus_Addr, o_DBus_WData, o_DBus_ByteEn, o_DBus_We} !==
                     {o.addr, o.wdata, o.byteen, o.we}) begin
          unstable++;
        end
        if (o.req_cycles - 1 == delay) begin
          i_DBus_Ack = 1'b1;
          i_DBus_RData = rdata;
          #1;
        end
      end
      was_stall = (o_Stall !== 1'b0);
      if (was_stall) o.stall_cycles++;
      @(posedge i_clk); #1;
      i_DBus_Ack = 1'b0;
      i_DBus_RData = $urandom;
      if (!was_stall) begin
        o.valid = o_Valid; o.ctl = o_WB_Control; o.rd = o_rd; o.alu = o_AluOutput;
        o.mem = o_MemoryValue; o.fault = o_Fault;
        done = 1;
      end else if (o_Valid !== 1'b0 || o_WB_Control[0] !== 1'b0) begin
        bad_bubbles++;
      end
      cyc++;
    end
    hung = !done;
    i_Valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
  endtask

  task automatic idle_cycle();
    i_Valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    n_checks++; if (o_Valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%0h exp=0", o_Valid); end
    n_checks++; if (o_WB_Control !== 3'b000) begin n_errors++; $display("FAIL reset_wbctl got=%0h exp=0", o_WB_Control); end
    n_checks++; if (o_DBus_Req !== 1'b0) begin n_errors++; $display("FAIL reset_req got=%0h exp=0", o_DBus_Req); end
    n_checks++; if (o_Fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault got=%0h exp=0", o_Fault); end
    n_checks++; if (o_MemoryValue !== 32'h0) begin n_errors++; $display("FAIL reset_memval got=%0h exp=0", o_MemoryValue); end
    n_checks++; if (o_Stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%0h exp=0", o_Stall); end
  endtask

  task automatic test_alu();
    res_t o; int bb, us; bit hung;
    run_op(1'b1, 3'b001, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 0, o, bb, us, hung);
    n_checks++; if (hung) begin n_errors++; $display("FAIL alu_hung got=1 exp=0"); end
    n_checks++; if (o.stall_cycles != 0) begin n_errors++; $display("FAIL alu_stall got=%0d exp=0", o.stall_cycles); end
    n_checks++; if (o.valid !== 1'b1) begin n_errors++; $display("FAIL alu_valid got=%0h exp=1", o.valid); end
    n_checks++; if (o.alu !== 32'h1234) begin n_errors++; $display("FAIL alu_result got=%0h exp=1234", o.alu); end
    n_checks++; if (o.rd !== 5'd5) begin n_errors++; $display("FAIL alu_rd got=%0d exp=5", o.rd); end
    n_checks++; if (o.ctl !== 3'b001) begin n_errors++; $display("FAIL alu_wbctl got=%0h exp=1", o.ctl); end
  endtask

  task automatic test_load();
    res_t o; int bb, us; bit hung;
    run_op(1'b1, 3'b011, 5'd7, 32'h1003, 32'h0, 1'b1, 1'b0, 3'b000, 32'h80FF_FF7F, 0, o, bb, us, hung);
    n_checks++; if (o.mem !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_value got=%0h exp=ffffff80", o.mem); end
    n_checks++; if (o.stall_cycles != 1) begin n_errors++; $display("FAIL lb_stall got=%0d exp=1", o.stall_cycles); end
    n_checks++; if (o.addr !== 32'h1000) begin n_errors++; $display("FAIL lb_addr got=%0h exp=1000", o.addr); end
    n_checks++; if (o.valid !== 1'b1 || o.ctl !== 3'b011) begin n_errors++; $display("FAIL lb_wb got=%0h/%0h exp=1/3", o.valid, o.ctl); end
    run_op(1'b1, 3'b011, 5'd7, 32'h1003, 32'h0, 1'b1, 1'b0, 3'b100, 32'h80FF_FF7F, 0, o, bb, us, hung);
    n_checks++; if (o.mem !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_value got=%0h exp=80", o.mem); end
    n_checks++; if (o.stall_cycles != 1) begin n_errors++; $display("FAIL lbu_stall got=%0d exp=1", o.stall_cycles); end
  endtask

  task automatic test_store();
    res_t o; int bb, us; bit hung;
    run_op(1'b1, 3'b000, 5'd0, 32'h2002, 32'hABCD_1234, 1'b0, 1'b1, 3'b001, 32'h0, 3, o, bb, us, hung);
    n_checks++; if (o.addr !== 32'h2000) begin n_errors++; $display("FAIL sh_addr got=%0h exp=2000", o.addr); end
    n_checks++; if (o.wdata !== 32'h1234_1234) begin n_errors++; $display("FAIL sh_wdata got=%0h exp=12341234", o.wdata); end
    n_checks++; if (o.byteen !== 4'b1100) begin n_errors++; $display("FAIL sh_byteen got=%0b exp=1100", o.byteen); end
    n_checks++; if (o.we !== 1'b1) begin n_errors++; $display("FAIL sh_we got=%0h exp=1", o.we); end
    n_checks++; if (o.req_cycles != 4) begin n_errors++; $display("FAIL sh_req_cycles got=%0d exp=4", o.req_cycles); end
    n_checks++; if (bb != 0 || us != 0) begin n_errors++; $display("FAIL sh_bubble_stable got=%0d/%0d exp=0/0", bb, us); end
    n_checks++; if (o.valid !== 1'b1 || o.fault !== 1'b0) begin n_errors++; $display("FAIL sh_wb got=%0h/%0h exp=1/0", o.valid, o.fault); end
    n_checks++; if (o_DBus_Req !== 1'b0) begin n_errors++; $display("FAIL sh_req_drop got=%0h exp=0", o_DBus_Req); end
  endtask

  task automatic test_misaligned();
    res_t o; int bb, us; bit hung;
    run_op(1'b1, 3'b011, 5'd9, 32'h0006, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 0, o, bb, us, hung);
    n_checks++; if (o.fault !== 1'b1) begin n_errors++; $display("FAIL lw_mis_fault got=%0h exp=1", o.fault); end
    n_checks++; if (o.ctl !== 3'b010) begin n_errors++; $display("FAIL lw_mis_wbctl got=%0h exp=2", o.ctl); end
    n_checks++; if (o.req_cycles != 0 || o.stall_cycles != 0) begin n_errors++; $display("FAIL lw_mis_bus got=%0d/%0d exp=0/0", o.req_cycles, o.stall_cycles); end
    idle_cycle();
    n_checks++; if (o_Fault !== 1'b0) begin n_errors++; $display("FAIL fault_pulse got=%0h exp=0", o_Fault); end
  endtask

  task automatic test_timeout();
    res_t o; int bb, us; bit hung;
    run_op(1'b1, 3'b011, 5'd3, 32'h0040, 32'h0, 1'b1, 1'b0, 3'b010, 32'h5555_AAAA, 99, o, bb, us, hung);
    n_checks++; if (hung) begin n_errors++; $display("FAIL to_hung got=1 exp=0"); end
    n_checks++; if (o.req_cycles != TO) begin n_errors++; $display("FAIL to_req_cycles got=%0d exp=%0d", o.req_cycles, TO); end
    n_checks++; if (o.fault !== 1'b1 || o.ctl[0] !== 1'b0) begin n_errors++; $display("FAIL to_fault got=%0h/%0h exp=1/0", o.fault, o.ctl[0]); end
    n_checks++; if (o_DBus_Req !== 1'b0) begin n_errors++; $display("FAIL to_req_drop got=%0h exp=0", o_DBus_Req); end
    idle_cycle();
    i_DBus_Ack = 1'b1; #1;
    n_checks++; if (o_Stall !== 1'b0 || o_DBus_Req !== 1'b0) begin n_errors++; $display("FAIL late_ack_comb got=%0h/%0h exp=0/0", o_Stall, o_DBus_Req); end
    @(posedge i_clk); #1; i_DBus_Ack = 1'b0;
    n_checks++; if (o_Valid !== 1'b0 || o_Fault !== 1'b0 || o_DBus_Req !== 1'b0) begin n_errors++; $display("FAIL late_ack got=%0h/%0h/%0h exp=0/0/0", o_Valid, o_Fault, o_DBus_Req); end
  endtask

  task automatic test_reset_mid_access();
    res_t o; int bb, us; bit hung;
    i_Valid = 1'b1; i_WB_Control = 3'b011; i_rd = 5'd4; i_AluOutput = 32'h80;
    i_MemRead = 1'b1; i_MemWrite = 1'b0; i_MemFunct3 = 3'b010;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    n_checks++; if (o_DBus_Req !== 1'b1) begin n_errors++; $display("FAIL rst_pre_req got=%0h exp=1", o_DBus_Req); end
    #1 i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_DBus_Req !== 1'b0) begin n_errors++; $display("FAIL rst_async_req got=%0h exp=0", o_DBus_Req); end
    @(negedge i_clk);
    i_Valid = 1'b0; i_MemRead = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++; if (o_Valid !== 1'b0 || o_DBus_Req !== 1'b0 || o_Stall !== 1'b0) begin n_errors++; $display("FAIL rst_after got=%0h/%0h/%0h exp=0/0/0", o_Valid, o_DBus_Req, o_Stall); end
    run_op(1'b1, 3'b001, 5'd6, 32'hBEEF, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 0, o, bb, us, hung);
    n_checks++; if (o.stall_cycles != 0 || o.valid !== 1'b1 || o.alu !== 32'hBEEF) begin n_errors++; $display("FAIL rst_idle_op got=%0d/%0h/%0h exp=0/1/beef", o.stall_cycles, o.valid, o.alu); end
  endtask

  task automatic test_random();
    res_t o, e; int bb, us, kind, delay; bit hung;
    logic v, mr, mw; logic [2:0] f3, ctl; logic [4:0] rd; logic [31:0] alu, sd, rdata;
    logic [2:0] lf3 [5];
    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      v = 1'b1; mr = 1'b0; mw = 1'b0; f3 = 3'($urandom);
      ctl = 3'($urandom); rd = 5'($urandom); alu = $urandom; sd = $urandom; rdata = $urandom;
      delay = $urandom_range(0, 5);
      if (kind == 3) begin v = 1'b0; mr = 1'($urandom); end
      else if (kind >= 4 && kind <= 6) begin mr = 1'b1; f3 = lf3[$urandom_range(0, 4)]; end
      else if (kind == 7 || kind == 8) begin mw = 1'b1; f3 = lf3[$urandom_range(0, 2)]; end
      else if (kind == 9) begin mr = 1'($urandom); mw = ~mr | 1'($urandom); end
      e = model(v, ctl, rd, alu, sd, mr, mw, f3, rdata, delay);
      run_op(v, ctl, rd, alu, sd, mr, mw, f3, rdata, delay, o, bb, us, hung);
      n_checks++; if (hung) begin n_errors++; $display("FAIL rnd%0d hung got=1 exp=0", i); end
      n_checks++; if ({o.valid, o.ctl, o.rd, o.alu} !== {e.valid, e.ctl, e.rd, e.alu}) begin n_errors++;
        $display("FAIL rnd%0d wb got=%0h/%0h/%0d/%0h exp=%0h/%0h/%0d/%0h", i, o.valid, o.ctl, o.rd, o.alu, e.valid, e.ctl, e.rd, e.alu); end
      n_checks++; if (o.mem !== e.mem) begin n_errors++; $display("FAIL rnd%0d memval got=%0h exp=%0h", i, o.mem, e.mem); end
      n_checks++; if (o.fault !== e.fault) begin n_errors++; $display("FAIL rnd%0d fault got=%0h exp=%0h", i, o.fault, e.fault); end
      n_checks++; if (o.stall_cycles != e.stall_cycles || o.req_cycles != e.req_cycles) begin n_errors++;
        $display("FAIL rnd%0d timing got=%0d/%0d exp=%0d/%0d", i, o.stall_cycles, o.req_cycles, e.stall_cycles, e.req_cycles); end
      n_checks++; if (bb != 0 || us != 0) begin n_errors++; $display("FAIL rnd%0d bubble_stable got=%0d/%0d exp=0/0", i, bb, us); end
      if (e.req_cycles > 0) begin
        n_checks++; if (o.addr !== e.addr || o.we !== e.we) begin n_errors++; $display("FAIL rnd%0d bus_addr got=%0h/%0h exp=%0h/%0h", i, o.addr, o.we, e.addr, e.we); end
        if (e.we) begin
          n_checks++; if (o.wdata !== e.wdata || o.byteen !== e.byteen) begin n_errors++;
            $display("FAIL rnd%0d bus_store got=%0h/%0b exp=%0h/%0b", i, o.wdata, o.byteen, e.wdata, e.byteen); end
        end
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
